// File: rtl/seq_pattern_gen_if.sv
// Bus bundle for seq_pattern_gen: pattern load, transmit control and serial output framing.
interface seq_pattern_gen_if #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned LEN_W = 5
);
  logic             load;
  logic [WIDTH-1:0] pattern_in;
  logic [LEN_W-1:0] len_in;
  logic             start;
  logic             stop;
  logic             cont;
  logic             seq;
  logic             seq_valid;
  logic             busy;
  logic             done;
  logic [7:0]       frame_cnt;

  modport master (
    output load, pattern_in, len_in, start, stop, cont,
    input  seq, seq_valid, busy, done, frame_cnt
  );

  modport slave (
    input  load, pattern_in, len_in, start, stop, cont,
    output seq, seq_valid, busy, done, frame_cnt
  );
endinterface

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: shifts a programmable pattern out on seq, one-shot or continuous.
// Optional even-parity trailer bit per frame when SEQ_GEN_PARITY_EN is defined.
module seq_pattern_gen #(
  parameter int unsigned      WIDTH     = 18,
  parameter int unsigned      LEN_W     = 5,
  parameter logic [WIDTH-1:0] DEF_PAT   = 18'b001_01100100_1101001,
  parameter bit               LSB_FIRST = 1'b1
) (
  input logic              clk,
  input logic              rst,
  seq_pattern_gen_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q;
  logic [LEN_W-1:0] last_idx;
  logic             cont_q;
  logic             seq_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;
  logic [7:0]       cnt_q;
  logic             load_ok;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    if (l == '0 || l > LEN_W'(WIDTH)) return LEN_W'(WIDTH);
    return l;
  endfunction

`ifdef SEQ_GEN_PARITY_EN
  function automatic logic parity(input logic [WIDTH-1:0] pat, input logic [LEN_W-1:0] len);
    logic p;
    p = 1'b0;
    for (int unsigned k = 0; k < WIDTH; k++)
      if (k < 32'(len)) p ^= pat[k];
    return p;
  endfunction
`endif

  // Index len selects the parity slot; below that, the pattern bit in send order.
  function automatic logic frame_bit(input logic [WIDTH-1:0] pat,
                                     input logic [LEN_W-1:0] len,
                                     input logic [LEN_W-1:0] i);
    logic [LEN_W-1:0] pos;
`ifdef SEQ_GEN_PARITY_EN
    if (i == len) return parity(pat, len);
`endif
    pos = LSB_FIRST ? i : LEN_W'(len - LEN_W'(1) - i);
    return pat[pos];
  endfunction

  // Load is resolved combinationally so a same-edge start already sends the new pattern.
  always_comb begin
    load_ok = (state_q == IDLE) && bus.load && !bus.stop;
    pat_d   = load_ok ? bus.pattern_in : pat_q;
    len_d   = load_ok ? clamp_len(bus.len_in) : len_q;
`ifdef SEQ_GEN_PARITY_EN
    last_idx = len_q;
`else
    last_idx = LEN_W'(len_q - LEN_W'(1));
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pat_q   <= DEF_PAT;
      len_q   <= LEN_W'(WIDTH);
      idx_q   <= '0;
      cont_q  <= 1'b0;
      seq_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pat_q  <= pat_d;
      len_q  <= len_d;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start && !bus.stop) begin
            state_q <= RUN;
            idx_q   <= '0;
            seq_q   <= frame_bit(pat_d, len_d, '0);
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            cont_q  <= bus.cont;
          end
        end
        RUN: begin
          if (bus.stop) begin
            state_q <= IDLE;
            idx_q   <= '0;
            seq_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end else if (idx_q == last_idx) begin
            cnt_q <= cnt_q + 8'd1;
            idx_q <= '0;
            if (cont_q) begin
              seq_q <= frame_bit(pat_q, len_q, '0);
            end else begin
              state_q <= IDLE;
              seq_q   <= 1'b0;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            idx_q <= idx_q + LEN_W'(1);
            seq_q <= frame_bit(pat_q, len_q, idx_q + LEN_W'(1));
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.seq       = seq_q;
  assign bus.seq_valid = valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.frame_cnt = cnt_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Self-checking bench for seq_pattern_gen against a queue-based frame model.
module tb_seq_pattern_gen;
  localparam int unsigned WIDTH = 18;
  localparam int unsigned LEN_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   exp_q[$];

  always #5 clk = ~clk;

  seq_pattern_gen_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) bus ();

  seq_pattern_gen #(
    .WIDTH    (WIDTH),
    .LEN_W    (LEN_W),
    .DEF_PAT  (18'b001_01100100_1101001),
    .LSB_FIRST(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected frame: first n pattern bits LSB first, plus even parity when enabled.
  function automatic void build_frame(input logic [17:0] pat, input int len);
    int n;
    bit p;
    n = (len == 0 || len > 18) ? 18 : len;
    p = 1'b0;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(pat[i]);
      p ^= pat[i];
    end
`ifdef SEQ_GEN_PARITY_EN
    exp_q.push_back(p);
`endif
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    repeat (4) tick();
    checks++; if (bus.seq !== 1'b0) begin errors++; $display("FAIL reset_seq got=%b exp=0", bus.seq); end
    checks++; if (bus.seq_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.seq_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.frame_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", bus.frame_cnt); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_start_stop_idle();
    bus.start = 1'b1; bus.stop = 1'b1;
    tick();
    bus.start = 1'b0; bus.stop = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL startstop_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.seq_valid !== 1'b0) begin errors++; $display("FAIL startstop_valid got=%b exp=0", bus.seq_valid); end
    tick();
  endtask

  // Default pattern frame, expected bits listed in send order (first bit at [17]).
  task automatic test_default_pattern(input string name);
    logic [17:0] order;
    int          n;
    order = 18'b100101100100110100;
    exp_q.delete();
    for (int j = 0; j < 18; j++) exp_q.push_back(order[17 - j]);
`ifdef SEQ_GEN_PARITY_EN
    exp_q.push_back(1'b0);
`endif
    n = exp_q.size();
    bus.cont = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int j = 0; j < n; j++) begin
      checks++;
      if (bus.seq_valid !== 1'b1 || bus.seq !== exp_q[j]) begin
        errors++; $display("FAIL %s bit%0d got seq=%b valid=%b exp seq=%b valid=1", name, j, bus.seq, bus.seq_valid, exp_q[j]);
      end
      tick();
    end
    checks++; if (bus.done !== 1'b1 || bus.seq_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL %s_end got done=%b valid=%b busy=%b exp 1/0/0", name, bus.done, bus.seq_valid, bus.busy);
    end
    checks++; if (bus.frame_cnt !== 8'd1) begin errors++; $display("FAIL %s_cnt got=%0d exp=1", name, bus.frame_cnt); end
    tick();
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL %s_donepulse got=%b exp=0", name, bus.done); end
  endtask

  task automatic test_load_ignore();
    bus.pattern_in = 18'h00005; bus.len_in = 5'd4; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    build_frame(18'h00005, 4);
    for (int f = 0; f < 2; f++) begin
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int j = 0; j < exp_q.size(); j++) begin
        checks++;
        if (bus.seq_valid !== 1'b1 || bus.seq !== exp_q[j]) begin
          errors++; $display("FAIL load_frame%0d bit%0d got seq=%b valid=%b exp seq=%b", f, j, bus.seq, bus.seq_valid, exp_q[j]);
        end
        if (f == 1 && j == 0) begin
          bus.pattern_in = 18'h3FFFF; bus.len_in = 5'd7; bus.load = 1'b1;
        end
        tick();
      end
      bus.load = 1'b0;
      checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL load_done%0d got=%b exp=1", f, bus.done); end
      tick();
    end
  endtask

  task automatic test_cont_stop();
    bus.pattern_in = 18'b110; bus.len_in = 5'd3; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    build_frame(18'b110, 3);
    bus.cont = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0; bus.cont = 1'b0;
    for (int f = 0; f < 3; f++) begin
      for (int j = 0; j < exp_q.size(); j++) begin
        checks++;
        if (bus.seq_valid !== 1'b1 || bus.seq !== exp_q[j] || bus.frame_cnt !== 8'(f)) begin
          errors++; $display("FAIL cont f%0d bit%0d got seq=%b valid=%b cnt=%0d exp seq=%b cnt=%0d", f, j, bus.seq, bus.seq_valid, bus.frame_cnt, exp_q[j], f);
        end
        if (f == 2 && j == 2) bus.stop = 1'b1;
        tick();
        if (f == 2 && j == 2) break;
      end
    end
    bus.stop = 1'b0;
    checks++; if (bus.seq_valid !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL cont_stop got valid=%b done=%b busy=%b exp 0/0/0", bus.seq_valid, bus.done, bus.busy);
    end
    checks++; if (bus.frame_cnt !== 8'd2) begin errors++; $display("FAIL cont_stop_cnt got=%0d exp=2", bus.frame_cnt); end
    tick();
  endtask

  task automatic test_reset_midframe();
    bus.pattern_in = 18'h2AAAA; bus.len_in = 5'd18; bus.load = 1'b1; bus.start = 1'b1;
    tick();
    bus.load = 1'b0; bus.start = 1'b0;
    repeat (7) tick();
    #2 rst = 1'b0;
    #1;
    checks++; if (bus.seq !== 1'b0 || bus.seq_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.frame_cnt !== 8'd0) begin
      errors++; $display("FAIL midreset got seq=%b valid=%b busy=%b done=%b cnt=%0d exp all 0", bus.seq, bus.seq_valid, bus.busy, bus.done, bus.frame_cnt);
    end
    tick(); tick();
    rst = 1'b1;
    tick();
    test_default_pattern("midreset_def");
  endtask

`ifdef SEQ_GEN_PARITY_EN
  task automatic test_parity();
    logic [4:0] want;
    int         nvalid;
    want = 5'b11101;
    bus.pattern_in = 18'b0111; bus.len_in = 5'd4; bus.load = 1'b1; bus.start = 1'b1;
    tick();
    bus.load = 1'b0; bus.start = 1'b0;
    for (int j = 0; j < 5; j++) begin
      checks++;
      if (bus.seq_valid !== 1'b1 || bus.seq !== want[4 - j]) begin
        errors++; $display("FAIL parity bit%0d got seq=%b valid=%b exp seq=%b", j, bus.seq, bus.seq_valid, want[4 - j]);
      end
      tick();
    end
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL parity_done got=%b exp=1", bus.done); end
    tick();
    bus.pattern_in = 18'($urandom); bus.len_in = 5'd0; bus.load = 1'b1; bus.start = 1'b1;
    tick();
    bus.load = 1'b0; bus.start = 1'b0;
    nvalid = 0;
    for (int j = 0; j < 40 && bus.seq_valid === 1'b1; j++) begin
      nvalid++;
      tick();
    end
    checks++; if (nvalid != 19) begin errors++; $display("FAIL parity_clamp got=%0d valid clks exp=19", nvalid); end
    tick();
  endtask
`endif

  task automatic test_random();
    logic [17:0] pat;
    int          len, n, nf, sp, total;
    for (int it = 0; it < 12; it++) begin
      pat = 18'($urandom);
      len = int'($urandom_range(0, 31));
      build_frame(pat, len);
      n = exp_q.size();
      bus.pattern_in = pat; bus.len_in = 5'(len); bus.load = 1'b1; bus.start = 1'b1; bus.cont = 1'b0;
      tick();
      bus.load = 1'b0; bus.start = 1'b0;
      for (int j = 0; j < n; j++) begin
        checks++;
        if (bus.seq_valid !== 1'b1 || bus.seq !== exp_q[j]) begin
          errors++; $display("FAIL rand%0d bit%0d got seq=%b valid=%b exp seq=%b (pat=%h len=%0d)", it, j, bus.seq, bus.seq_valid, exp_q[j], pat, len);
        end
        tick();
      end
      checks++; if (bus.done !== 1'b1 || bus.frame_cnt !== 8'd1) begin
        errors++; $display("FAIL rand%0d_end got done=%b cnt=%0d exp done=1 cnt=1", it, bus.done, bus.frame_cnt);
      end
      tick();
      // Continuous run of the same pattern, aborted at a random bit.
      nf = int'($urandom_range(0, 3));
      sp = int'($urandom_range(0, n - 1));
      total = nf * n + sp + 1;
      bus.cont = 1'b1; bus.start = 1'b1;
      tick();
      bus.start = 1'b0; bus.cont = 1'b0;
      for (int k = 0; k < total; k++) begin
        checks++;
        if (bus.seq_valid !== 1'b1 || bus.seq !== exp_q[k % n] || bus.frame_cnt !== 8'(k / n)) begin
          errors++; $display("FAIL randcont%0d k%0d got seq=%b valid=%b cnt=%0d exp seq=%b cnt=%0d", it, k, bus.seq, bus.seq_valid, bus.frame_cnt, exp_q[k % n], k / n);
        end
        if (k == total - 1) bus.stop = 1'b1;
        tick();
      end
      bus.stop = 1'b0;
      checks++; if (bus.seq_valid !== 1'b0 || bus.done !== 1'b0 || bus.frame_cnt !== 8'(nf)) begin
        errors++; $display("FAIL randstop%0d got valid=%b done=%b cnt=%0d exp 0/0/%0d", it, bus.seq_valid, bus.done, bus.frame_cnt, nf);
      end
      tick();
    end
  endtask

  initial begin
    bus.load = 1'b0; bus.pattern_in = '0; bus.len_in = '0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.cont = 1'b0;
    test_reset();
    test_start_stop_idle();
    test_default_pattern("default");
    test_load_ignore();
    test_cont_stop();
    test_reset_midframe();
`ifdef SEQ_GEN_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
